// File: rtl/main_fsm_pkg.sv
// Shared types for the multi-cycle RISC-V main control FSM: state encoding,
// supported opcodes, datapath mux select encodings and the control bundle.
package main_fsm_pkg;

   localparam int OP_W_DEF = 7;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALU_OUT = 2'b00;
   localparam logic [1:0] RES_DATA    = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_e;

   typedef struct packed {
      logic       ir_write;
      logic       pc_update;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
             (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, control strobes and
// mux selects out. master = main control FSM, slave = datapath.
interface main_fsm_if #(parameter int OP_W = 7);

   logic [OP_W-1:0] op;
   logic            mem_ready;
   logic            ir_write;
   logic            pc_update;
   logic            reg_write;
   logic            mem_write;
   logic            branch;
   logic            adr_src;
   logic [1:0]      alu_src_a;
   logic [1:0]      alu_src_b;
   logic [1:0]      result_src;
   logic [1:0]      alu_op;
   logic            illegal;

   // mem_ready is a level: the access completes in any cycle it is high.
   modport master (
      input  op, mem_ready,
      output ir_write, pc_update, reg_write, mem_write, branch, adr_src,
             alu_src_a, alu_src_b, result_src, alu_op, illegal
   );

   modport slave (
      output op, mem_ready,
      input  ir_write, pc_update, reg_write, mem_write, branch, adr_src,
             alu_src_a, alu_src_b, result_src, alu_op, illegal
   );

endinterface

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control decoder. Moore outputs, except the fetch
// enables (follow mem ready) and the DECODE illegal-opcode pulse.
module main_fsm_outdec
   import main_fsm_pkg::*;
(
   input  logic       reset,
   input  state_e     state,
   input  logic [6:0] op,
   input  logic       mem_rdy,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.ir_write   = mem_rdy;
            ctrl.pc_update  = mem_rdy;
            ctrl.alu_src_a  = SRC_A_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.result_src = RES_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRC_A_OLD_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.illegal   = !is_legal_op(op);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         S_MEMREAD: begin
            ctrl.adr_src    = 1'b1;
            ctrl.result_src = RES_ALU_OUT;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.adr_src    = 1'b1;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.mem_write  = 1'b1;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         S_EXECI: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALU_OUT;
            ctrl.reg_write  = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a  = SRC_A_RS1;
            ctrl.alu_src_b  = SRC_B_RS2;
            ctrl.alu_op     = ALU_OP_SUB;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.branch     = 1'b1;
         end
         S_JAL: begin
            ctrl.alu_src_a  = SRC_A_OLD_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.pc_update  = 1'b1;
         end
         default: ctrl = '0;
      endcase
      // Reset is asynchronous, so strobes must vanish without waiting for a clock.
      if (reset) ctrl = '0;
   end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle RISC-V main control FSM: state register and next-state logic.
// Define MAIN_FSM_MEM_WAIT_EN to honour mem_ready stalls in FETCH/MEMREAD/MEMWRITE.
module main_fsm
   import main_fsm_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   main_fsm_if.master    bus,
   output state_e        state_o
);

   state_e state_q;
   logic   mem_rdy;
   ctrl_t  ctrl;

`ifdef MAIN_FSM_MEM_WAIT_EN
   assign mem_rdy = bus.mem_ready;
`else
   logic mem_ready_unused;
   assign mem_ready_unused = bus.mem_ready;
   assign mem_rdy          = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:    if (mem_rdy) state_q <= S_DECODE;
            S_DECODE: begin
               if (bus.op[6:0] == OP_LW || bus.op[6:0] == OP_SW) state_q <= S_MEMADR;
               else if (bus.op[6:0] == OP_R)   state_q <= S_EXECR;
               else if (bus.op[6:0] == OP_I)   state_q <= S_EXECI;
               else if (bus.op[6:0] == OP_BEQ) state_q <= S_BEQ;
               else if (bus.op[6:0] == OP_JAL) state_q <= S_JAL;
               else                            state_q <= S_FETCH;
            end
            S_MEMADR:   state_q <= (bus.op[6:0] == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_rdy) state_q <= S_MEMWB;
            S_MEMWB:    state_q <= S_FETCH;
            S_MEMWRITE: if (mem_rdy) state_q <= S_FETCH;
            S_EXECR:    state_q <= S_ALUWB;
            S_EXECI:    state_q <= S_ALUWB;
            S_ALUWB:    state_q <= S_FETCH;
            S_BEQ:      state_q <= S_FETCH;
            S_JAL:      state_q <= S_ALUWB;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   main_fsm_outdec u_outdec (
      .reset   (reset),
      .state   (state_q),
      .op      (bus.op[6:0]),
      .mem_rdy (mem_rdy),
      .ctrl    (ctrl)
   );

   assign bus.ir_write   = ctrl.ir_write;
   assign bus.pc_update  = ctrl.pc_update;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.branch     = ctrl.branch;
   assign bus.adr_src    = ctrl.adr_src;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.result_src = ctrl.result_src;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.illegal    = ctrl.illegal;
   assign state_o        = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-cycle state and control vectors checked
// against hand-written constants, with stall cases selected by MAIN_FSM_MEM_WAIT_EN.
module tb_main_fsm;
   import main_fsm_pkg::*;

   // {ir_write, pc_update, reg_write, mem_write, branch, adr_src,
   //  alu_src_a, alu_src_b, result_src, alu_op, illegal}
   localparam logic [14:0] C_ZERO     = 15'b000000_00_00_00_00_0;
   localparam logic [14:0] C_FETCH1   = 15'b110000_00_10_10_00_0;
   localparam logic [14:0] C_FETCH0   = 15'b000000_00_10_10_00_0;
   localparam logic [14:0] C_DECODE   = 15'b000000_01_01_00_00_0;
   localparam logic [14:0] C_DEC_ILL  = 15'b000000_01_01_00_00_1;
   localparam logic [14:0] C_MEMADR   = 15'b000000_10_01_00_00_0;
   localparam logic [14:0] C_MEMREAD  = 15'b000001_00_00_00_00_0;
   localparam logic [14:0] C_MEMWB    = 15'b001000_00_00_01_00_0;
   localparam logic [14:0] C_MEMWRITE = 15'b000101_00_00_00_00_0;
   localparam logic [14:0] C_EXECR    = 15'b000000_10_00_00_10_0;
   localparam logic [14:0] C_EXECI    = 15'b000000_10_01_00_10_0;
   localparam logic [14:0] C_ALUWB    = 15'b001000_00_00_00_00_0;
   localparam logic [14:0] C_BEQ      = 15'b000010_10_00_00_01_0;
   localparam logic [14:0] C_JAL      = 15'b010000_01_10_00_00_0;

`ifdef MAIN_FSM_MEM_WAIT_EN
   localparam logic [14:0] C_FETCH_RDY0 = C_FETCH0;
`else
   localparam logic [14:0] C_FETCH_RDY0 = C_FETCH1;
`endif

   logic        clk;
   logic        reset;
   state_e      state;
   logic [14:0] ctl;
   logic [14:0] exp_q[$];
   int          n_vec;
   int          n_err;

   main_fsm_if #(.OP_W(7)) bus ();

   main_fsm #(.OP_W(7)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (state)
   );

   assign ctl = {bus.ir_write, bus.pc_update, bus.reg_write, bus.mem_write,
                 bus.branch, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
                 bus.result_src, bus.alu_op, bus.illegal};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
   task automatic cyc(input string tag, input logic [6:0] op_v, input logic rdy,
                      input state_e exp_st, input logic [14:0] exp_c);
      bus.op        = op_v;
      bus.mem_ready = rdy;
      exp_q.push_back(exp_c);
      @(negedge clk);
      check({tag, "_st"}, 32'(state), 32'(exp_st));
      check({tag, "_ctl"}, 32'(ctl), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      reset         = 1'b1;
      bus.op        = OP_LW;
      bus.mem_ready = 1'b1;

      @(negedge clk);
      check("rst_st", 32'(state), 32'(S_FETCH));
      check("rst_ctl", 32'(ctl), 32'(C_ZERO));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // lw, no stalls: 5 cycles
      cyc("lw_f",   OP_LW, 1'b1, S_FETCH,   C_FETCH1);
      cyc("lw_d",   OP_LW, 1'b1, S_DECODE,  C_DECODE);
      cyc("lw_ma",  OP_LW, 1'b1, S_MEMADR,  C_MEMADR);
      cyc("lw_mr",  OP_LW, 1'b1, S_MEMREAD, C_MEMREAD);
      cyc("lw_wb",  OP_LW, 1'b1, S_MEMWB,   C_MEMWB);

      // sw, no stalls: 4 cycles
      cyc("sw_f",   OP_SW, 1'b1, S_FETCH,    C_FETCH1);
      cyc("sw_d",   OP_SW, 1'b1, S_DECODE,   C_DECODE);
      cyc("sw_ma",  OP_SW, 1'b1, S_MEMADR,   C_MEMADR);
      cyc("sw_mw",  OP_SW, 1'b1, S_MEMWRITE, C_MEMWRITE);

      // I-type
      cyc("i_f",    OP_I, 1'b1, S_FETCH,  C_FETCH1);
      cyc("i_d",    OP_I, 1'b1, S_DECODE, C_DECODE);
      cyc("i_ex",   OP_I, 1'b1, S_EXECI,  C_EXECI);
      cyc("i_wb",   OP_I, 1'b1, S_ALUWB,  C_ALUWB);

      // beq: 3 cycles
      cyc("beq_f",  OP_BEQ, 1'b1, S_FETCH,  C_FETCH1);
      cyc("beq_d",  OP_BEQ, 1'b1, S_DECODE, C_DECODE);
      cyc("beq_ex", OP_BEQ, 1'b1, S_BEQ,    C_BEQ);

      // jal: 4 cycles
      cyc("jal_f",  OP_JAL, 1'b1, S_FETCH,  C_FETCH1);
      cyc("jal_d",  OP_JAL, 1'b1, S_DECODE, C_DECODE);
      cyc("jal_j",  OP_JAL, 1'b1, S_JAL,    C_JAL);
      cyc("jal_wb", OP_JAL, 1'b1, S_ALUWB,  C_ALUWB);

      // unsupported opcodes: one-cycle illegal pulse, straight back to FETCH
      cyc("ill0_f", 7'b0000000, 1'b1, S_FETCH,  C_FETCH1);
      cyc("ill0_d", 7'b0000000, 1'b1, S_DECODE, C_DEC_ILL);
      cyc("ill1_f", 7'b1111111, 1'b1, S_FETCH,  C_FETCH1);
      cyc("ill1_d", 7'b1111111, 1'b1, S_DECODE, C_DEC_ILL);

`ifdef MAIN_FSM_MEM_WAIT_EN
      // fetch stall, then sw with three MEMWRITE stall cycles
      cyc("swst_f0", OP_SW, 1'b0, S_FETCH,    C_FETCH0);
      cyc("swst_f1", OP_SW, 1'b1, S_FETCH,    C_FETCH1);
      cyc("swst_d",  OP_SW, 1'b1, S_DECODE,   C_DECODE);
      cyc("swst_ma", OP_SW, 1'b1, S_MEMADR,   C_MEMADR);
      cyc("swst_w0", OP_SW, 1'b0, S_MEMWRITE, C_MEMWRITE);
      cyc("swst_w1", OP_SW, 1'b0, S_MEMWRITE, C_MEMWRITE);
      cyc("swst_w2", OP_SW, 1'b0, S_MEMWRITE, C_MEMWRITE);
      cyc("swst_w3", OP_SW, 1'b1, S_MEMWRITE, C_MEMWRITE);
      // lw with one MEMREAD stall
      cyc("lwst_f",  OP_LW, 1'b1, S_FETCH,   C_FETCH1);
      cyc("lwst_d",  OP_LW, 1'b1, S_DECODE,  C_DECODE);
      cyc("lwst_ma", OP_LW, 1'b1, S_MEMADR,  C_MEMADR);
      cyc("lwst_r0", OP_LW, 1'b0, S_MEMREAD, C_MEMREAD);
      cyc("lwst_r1", OP_LW, 1'b1, S_MEMREAD, C_MEMREAD);
      cyc("lwst_wb", OP_LW, 1'b0, S_MEMWB,   C_MEMWB);
`else
      // mem_ready ignored: R-type and lw run at full speed with mem_ready low
      cyc("rnr_f",  OP_R, 1'b0, S_FETCH,  C_FETCH1);
      cyc("rnr_d",  OP_R, 1'b0, S_DECODE, C_DECODE);
      cyc("rnr_ex", OP_R, 1'b0, S_EXECR,  C_EXECR);
      cyc("rnr_wb", OP_R, 1'b0, S_ALUWB,  C_ALUWB);
      cyc("lwnr_f",  OP_LW, 1'b0, S_FETCH,   C_FETCH1);
      cyc("lwnr_d",  OP_LW, 1'b0, S_DECODE,  C_DECODE);
      cyc("lwnr_ma", OP_LW, 1'b0, S_MEMADR,  C_MEMADR);
      cyc("lwnr_mr", OP_LW, 1'b0, S_MEMREAD, C_MEMREAD);
      cyc("lwnr_wb", OP_LW, 1'b0, S_MEMWB,   C_MEMWB);
`endif

      // reset asserted mid-MEMWRITE with mem_ready low
      cyc("rmw_f",  OP_SW, 1'b1, S_FETCH,  C_FETCH1);
      cyc("rmw_d",  OP_SW, 1'b1, S_DECODE, C_DECODE);
      cyc("rmw_ma", OP_SW, 1'b1, S_MEMADR, C_MEMADR);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("rmw_mw_st", 32'(state), 32'(S_MEMWRITE));
      check("rmw_mw_ctl", 32'(ctl), 32'(C_MEMWRITE));
      #1;
      reset = 1'b1;
      #1;
      check("rmw_rst_st", 32'(state), 32'(S_FETCH));
      check("rmw_rst_ctl", 32'(ctl), 32'(C_ZERO));
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("prst_f0", OP_R, 1'b0, S_FETCH, C_FETCH_RDY0);
`ifdef MAIN_FSM_MEM_WAIT_EN
      cyc("prst_f1", OP_R, 1'b1, S_FETCH, C_FETCH1);
`endif
      cyc("prst_d",  OP_R, 1'b1, S_DECODE, C_DECODE);
      cyc("prst_ex", OP_R, 1'b1, S_EXECR,  C_EXECR);
      cyc("prst_wb", OP_R, 1'b1, S_ALUWB,  C_ALUWB);
      cyc("end_f",   OP_R, 1'b1, S_FETCH,  C_FETCH1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle RISC-V main control state machine. Sequences the datapath's enable-reset registers, including the dual instruction/old-PC register, PC, register file and unified memory, through fetch, decode, execute and writeback for lw, sw, R-type, I-type ALU, beq and jal. Sits in the controller beside the ALU decoder and instruction-type decoder. Drives datapath write enables and mux selects each cycle.

## Interface
Parameters
- OP_W, 7, opcode field width

Ports
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  OP_W  instr[6:0] from the instruction register
- mem_ready  in  1  unified memory completes the access this cycle
- ir_write  out  1  enable for the instruction/old-PC register pair
- pc_update  out  1  PC write request (ORed with branch&zero externally)
- reg_write  out  1  register file write enable
- mem_write  out  1  memory write enable
- branch  out  1  conditional-branch qualifier
- adr_src  out  1  0 = PC, 1 = result bus as memory address
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1 register
- alu_src_b  out  2  00 rs2 register, 01 immediate, 10 constant 4
- result_src  out  2  00 ALUOut, 01 data register, 10 ALU result
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- illegal  out  1  one-cycle pulse, unsupported opcode seen in DECODE

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_update=mem_ready. Go to DECODE when mem_ready=1, else hold.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target).
  - Opcode 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - Any other opcode -> FETCH with illegal=1.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Go to MEMWB on mem_ready, else hold.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 every cycle held. Go to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB.
- Any field not listed for a state is driven to 0. Outputs are a Moore function of state, except ir_write/pc_update in FETCH and illegal in DECODE.
- Unreachable state encodings go to FETCH with all enables 0.

## Timing
- Reset:
  - State becomes FETCH immediately.
  - While reset=1, ir_write, pc_update, reg_write, mem_write and illegal are forced to 0. All other outputs are 0.
  - First fetch enable is possible in the first cycle after reset deasserts.
- Reset asserted mid-instruction abandons it. Any partially held mem_write drops in the same cycle.
- Cycle counts with mem_ready=1 constantly, each including FETCH:
  - lw 5
  - sw 4
  - R/I-type 4
  - beq 3
  - jal 4
- Each stall cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- ir_write is high for exactly one cycle per instruction, the cycle the fetch completes.

## Configuration
- MAIN_FSM_MEM_WAIT_EN defined: stall behaviour as specified above.
- MAIN_FSM_MEM_WAIT_EN undefined:
  - mem_ready is ignored and treated as 1.
  - FETCH, MEMREAD and MEMWRITE each last exactly one cycle.
  - ir_write/pc_update are high for the whole FETCH cycle.

## Structure
- Package main_fsm_pkg holds:
  - state enum
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - encodings for alu_src_a, alu_src_b, result_src and alu_op
- One sub-module, main_fsm_outdec: combinational state-to-control decoder.
- The state register and next-state logic stay in main_fsm.

## Test plan
- Reset, then lw (op=0000011), mem_ready=1:
  - State sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - reg_write=1 only in cycle 5.
  - ir_write=1 only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWRITE (macro defined):
  - mem_write=1 for 4 consecutive cycles.
  - FETCH follows the cycle where mem_ready=1.
- beq (1100011): branch=1 and alu_op=01 in cycle 3 only, back in FETCH on cycle 4. jal (1101111): pc_update=1 in the JAL cycle, then ALUWB with reg_write=1.
- Opcode 0000000 in DECODE: illegal=1 for one cycle, next state FETCH, no reg_write or mem_write at any point.
- Reset asserted during MEMWRITE with mem_ready=0:
  - mem_write drops in the same cycle.
  - After release, FETCH with ir_write=mem_ready.
- Macro undefined, mem_ready held 0: an R-type (0110011) still completes in 4 cycles, with reg_write=1 in cycle 4.
